// File: rtl/hood_disp_pkg.sv
// Shared types, glyph codes and segment patterns for the hood status display.
package hood_disp_pkg;

  typedef enum logic [3:0] {
    GLYPH_0     = 4'd0,
    GLYPH_1     = 4'd1,
    GLYPH_2     = 4'd2,
    GLYPH_3     = 4'd3,
    GLYPH_4     = 4'd4,
    GLYPH_5     = 4'd5,
    GLYPH_6     = 4'd6,
    GLYPH_7     = 4'd7,
    GLYPH_8     = 4'd8,
    GLYPH_9     = 4'd9,
    GLYPH_DASH  = 4'd10,
    GLYPH_BLANK = 4'd11,
    GLYPH_H     = 4'd12,
    GLYPH_L     = 4'd13,
    GLYPH_P     = 4'd14
  } glyph_e;

  typedef enum logic [1:0] {
    PAGE_CLOCK = 2'd0,
    PAGE_WORK  = 2'd1,
    PAGE_LEVEL = 2'd2
  } page_e;

  // Segment order {dp,g,f,e,d,c,b,a}, active-high.
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_H     = 8'h76;
  localparam logic [7:0] SEG_L     = 8'h38;
  localparam logic [7:0] SEG_P     = 8'h73;

  // One coherent sample of everything a frame shows.
  typedef struct packed {
    logic [5:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
    logic [5:0] work_hours;
    logic [5:0] work_minutes;
    logic [3:0] smoke_lvl;
    logic [5:0] hand_time;
    logic       remind;
    page_e      page;
  } snap_t;

  // Decimal digits 0..9 share their value with the glyph code.
  function automatic glyph_e digit_glyph(input logic [3:0] d);
    return glyph_e'(d);
  endfunction

  function automatic logic [7:0] glyph_to_seg(input glyph_e g);
    logic [7:0] s;
    case (g)
      GLYPH_0:    s = SEG_0;
      GLYPH_1:    s = SEG_1;
      GLYPH_2:    s = SEG_2;
      GLYPH_3:    s = SEG_3;
      GLYPH_4:    s = SEG_4;
      GLYPH_5:    s = SEG_5;
      GLYPH_6:    s = SEG_6;
      GLYPH_7:    s = SEG_7;
      GLYPH_8:    s = SEG_8;
      GLYPH_9:    s = SEG_9;
      GLYPH_DASH: s = SEG_DASH;
      GLYPH_H:    s = SEG_H;
      GLYPH_L:    s = SEG_L;
      GLYPH_P:    s = SEG_P;
      default:    s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/hood_bcd6.sv
// Combinational 6-bit binary (0..63) to two decimal digits.
module hood_bcd6 (
  input  logic [5:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o
);

  logic [5:0] base;

  always_comb begin
    tens_o = 4'd0;
    base   = 6'd0;
    if (bin_i >= 6'd60) begin
      tens_o = 4'd6;
      base   = 6'd60;
    end else if (bin_i >= 6'd50) begin
      tens_o = 4'd5;
      base   = 6'd50;
    end else if (bin_i >= 6'd40) begin
      tens_o = 4'd4;
      base   = 6'd40;
    end else if (bin_i >= 6'd30) begin
      tens_o = 4'd3;
      base   = 6'd30;
    end else if (bin_i >= 6'd20) begin
      tens_o = 4'd2;
      base   = 6'd20;
    end else if (bin_i >= 6'd10) begin
      tens_o = 4'd1;
      base   = 6'd10;
    end
    ones_o = 4'(bin_i - base);
  end

endmodule

// File: rtl/hood_display.sv
// Multiplexed 8-digit seven-segment driver for the range-hood status bus,
// with per-frame input snapshots, three pages and reminder blinking.
module hood_display
  import hood_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100_000,
  parameter int unsigned BLINK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic       page_pulse,
  input  logic       remind,
  input  logic [5:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic [5:0] work_hours,
  input  logic [5:0] work_minutes,
  input  logic [3:0] smoke_lvl,
  input  logic [5:0] hand_time,
  output logic [7:0] seg,
  output logic [7:0] an
);

  localparam int unsigned ScanW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned NumFields = 7;
  localparam int unsigned FldHour   = 0;
  localparam int unsigned FldMin    = 1;
  localparam int unsigned FldSec    = 2;
  localparam int unsigned FldWh     = 3;
  localparam int unsigned FldWm     = 4;
  localparam int unsigned FldLvl    = 5;
  localparam int unsigned FldHand   = 6;

  logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_on_q, blink_on_d;
  logic [2:0]        dig_q, dig_d;
  page_e             page_q, page_d;
  snap_t             shadow_q, shadow_d;
  logic [7:0]        seg_q, seg_d;
  logic [7:0]        an_q, an_d;

  logic              scan_tick;
  logic              blink_tc;
  logic              frame_wrap;
  logic [2:0]        pos;
  glyph_e            glyph;
  logic [5:0]        field_bin  [NumFields];
  logic [3:0]        field_tens [NumFields];
  logic [3:0]        field_ones [NumFields];

  assign scan_tick  = (scan_cnt_q == ScanW'(SCAN_DIV - 1));
  assign blink_tc   = (blink_cnt_q == BlinkW'(BLINK_DIV - 1));
  assign frame_wrap = scan_tick && (dig_q == 3'd7);
  // Digit index 0 is the leftmost digit, driven by an[7].
  assign pos        = ~dig_d;

  always_comb begin
    scan_cnt_d  = scan_tick ? '0 : scan_cnt_q + 1'b1;
    dig_d       = scan_tick ? dig_q + 3'd1 : dig_q;
    blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = blink_tc ? ~blink_on_q : blink_on_q;
  end

  always_comb begin
    page_d = page_q;
    if (!power_on) begin
      page_d = PAGE_CLOCK;
    end else if (page_pulse) begin
      case (page_q)
        PAGE_CLOCK: page_d = PAGE_WORK;
        PAGE_WORK:  page_d = PAGE_LEVEL;
        default:    page_d = PAGE_CLOCK;
      endcase
    end
  end

  // Capture the whole frame's inputs at once so a frame never mixes samples.
  always_comb begin
    shadow_d = shadow_q;
    if (frame_wrap) begin
      shadow_d.hour         = hour;
      shadow_d.minute       = minute;
      shadow_d.second       = second;
      shadow_d.work_hours   = work_hours;
      shadow_d.work_minutes = work_minutes;
      shadow_d.smoke_lvl    = smoke_lvl;
      shadow_d.hand_time    = hand_time;
      shadow_d.remind       = remind;
      shadow_d.page         = page_q;
    end
    // Keeps a stale page from surviving a short power-off.
    if (!power_on) begin
      shadow_d.page = PAGE_CLOCK;
    end
  end

  always_comb begin
    field_bin[FldHour] = shadow_d.hour;
    field_bin[FldMin]  = shadow_d.minute;
    field_bin[FldSec]  = shadow_d.second;
    field_bin[FldWh]   = shadow_d.work_hours;
    field_bin[FldWm]   = shadow_d.work_minutes;
    field_bin[FldLvl]  = {2'b00, shadow_d.smoke_lvl};
    field_bin[FldHand] = shadow_d.hand_time;
  end

  for (genvar i = 0; i < NumFields; i++) begin : g_bcd
    hood_bcd6 u_bcd (
      .bin_i  (field_bin[i]),
      .tens_o (field_tens[i]),
      .ones_o (field_ones[i])
    );
  end

  always_comb begin
    glyph = GLYPH_BLANK;
    case (shadow_d.page)
      PAGE_WORK: begin
        unique case (pos)
          3'd7:       glyph = GLYPH_H;
          3'd6, 3'd5: glyph = GLYPH_BLANK;
          3'd4:       glyph = digit_glyph(field_tens[FldWh]);
          3'd3:       glyph = digit_glyph(field_ones[FldWh]);
          3'd2:       glyph = GLYPH_DASH;
          3'd1:       glyph = digit_glyph(field_tens[FldWm]);
          3'd0:       glyph = digit_glyph(field_ones[FldWm]);
        endcase
      end
      PAGE_LEVEL: begin
        unique case (pos)
          3'd7:       glyph = GLYPH_L;
          3'd6:       glyph = digit_glyph(field_tens[FldLvl]);
          3'd5:       glyph = digit_glyph(field_ones[FldLvl]);
          3'd4, 3'd3: glyph = GLYPH_BLANK;
          3'd2:       glyph = GLYPH_P;
          3'd1:       glyph = digit_glyph(field_tens[FldHand]);
          3'd0:       glyph = digit_glyph(field_ones[FldHand]);
        endcase
      end
      default: begin
        unique case (pos)
          3'd7:       glyph = digit_glyph(field_tens[FldHour]);
          3'd6:       glyph = digit_glyph(field_ones[FldHour]);
          3'd5, 3'd2: glyph = GLYPH_DASH;
          3'd4:       glyph = digit_glyph(field_tens[FldMin]);
          3'd3:       glyph = digit_glyph(field_ones[FldMin]);
          3'd1:       glyph = digit_glyph(field_tens[FldSec]);
          3'd0:       glyph = digit_glyph(field_ones[FldSec]);
        endcase
      end
    endcase
  end

  // Segments and anode share one register stage, so there is no ghosting cycle.
  always_comb begin
    seg_d = seg_q;
    an_d  = an_q;
    if (!power_on) begin
      seg_d = '0;
      an_d  = '0;
    end else if (scan_tick) begin
      an_d  = 8'd1 << pos;
      seg_d = (shadow_d.remind && !blink_on_q) ? SEG_BLANK : glyph_to_seg(glyph);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt_q  <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      dig_q       <= 3'd0;
      page_q      <= PAGE_CLOCK;
      shadow_q    <= '0;
      seg_q       <= '0;
      an_q        <= '0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      dig_q       <= dig_d;
      page_q      <= page_d;
      shadow_q    <= shadow_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_hood_display.sv
// Self-checking bench for hood_display: directed page/snapshot/blink/power
// scenarios plus randomized traffic against a cycle-count reference model.
module tb_hood_display;

  localparam int SCAN  = 4;
  localparam int BLINK = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       power_on = 1'b0;
  logic       page_pulse = 1'b0;
  logic       remind = 1'b0;
  logic [5:0] hour = '0, minute = '0, second = '0;
  logic [5:0] work_hours = '0, work_minutes = '0, hand_time = '0;
  logic [3:0] smoke_lvl = '0;
  logic [7:0] seg, an;

  int checks = 0;
  int failures = 0;

  hood_display #(.SCAN_DIV(SCAN), .BLINK_DIV(BLINK)) dut (
    .clk          (clk),
    .reset        (reset),
    .power_on     (power_on),
    .page_pulse   (page_pulse),
    .remind       (remind),
    .hour         (hour),
    .minute       (minute),
    .second       (second),
    .work_hours   (work_hours),
    .work_minutes (work_minutes),
    .smoke_lvl    (smoke_lvl),
    .hand_time    (hand_time),
    .seg          (seg),
    .an           (an)
  );

  always #5 clk = ~clk;

  // Reference model: everything derived from the edge count since reset release.
  int k = 0;
  int m_page = 0;
  int s_h = 0, s_m = 0, s_s = 0, s_wh = 0, s_wm = 0, s_lv = 0, s_ht = 0, s_page = 0;
  bit s_rem = 1'b0;
  logic [7:0] exp_seg = '0, exp_an = '0;

  function automatic logic [7:0] glyph_seg(input int g);
    case (g)
      0: return 8'h3F;  1: return 8'h06;  2: return 8'h5B;  3: return 8'h4F;
      4: return 8'h66;  5: return 8'h6D;  6: return 8'h7D;  7: return 8'h07;
      8: return 8'h7F;  9: return 8'h6F;  10: return 8'h40; 11: return 8'h00;
      12: return 8'h76; 13: return 8'h38; 14: return 8'h73;
      default: return 8'hFF;
    endcase
  endfunction

  // idx 0 = leftmost digit; 10 dash, 11 blank, 12 H, 13 L, 14 P.
  function automatic logic [7:0] model_seg(input int idx);
    int g[8];
    case (s_page)
      1: g = '{12, 11, 11, s_wh / 10, s_wh % 10, 10, s_wm / 10, s_wm % 10};
      2: g = '{13, s_lv / 10, s_lv % 10, 11, 11, 14, s_ht / 10, s_ht % 10};
      default: g = '{s_h / 10, s_h % 10, 10, s_m / 10, s_m % 10, 10, s_s / 10, s_s % 10};
    endcase
    return glyph_seg(g[idx]);
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        k = 0; m_page = 0; s_page = 0; s_rem = 1'b0;
        s_h = 0; s_m = 0; s_s = 0; s_wh = 0; s_wm = 0; s_lv = 0; s_ht = 0;
        exp_seg = '0; exp_an = '0;
      end else begin
        k++;
        if ((k % SCAN == 0) && ((k / SCAN) % 8 == 0)) begin
          s_h = int'(hour); s_m = int'(minute); s_s = int'(second);
          s_wh = int'(work_hours); s_wm = int'(work_minutes);
          s_lv = int'(smoke_lvl); s_ht = int'(hand_time);
          s_rem = remind; s_page = m_page;
        end
        if (!power_on) s_page = 0;
        if (!power_on) begin
          exp_seg = '0; exp_an = '0;
        end else if (k % SCAN == 0) begin
          exp_an  = 8'h80 >> ((k / SCAN) % 8);
          exp_seg = (s_rem && (((k - 1) / BLINK) % 2 == 1)) ? 8'h00
                                                              : model_seg((k / SCAN) % 8);
        end
        if (!power_on) m_page = 0;
        else if (page_pulse) m_page = (m_page + 1) % 3;
      end
    end
  end

  logic [7:0] seen [8];

  // Records the last segment pattern shown on each anode over n cycles.
  task automatic capture(input int n);
    for (int i = 0; i < 8; i++) seen[i] = 8'hEE;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int b = 0; b < 8; b++) if (an == (8'h01 << b)) seen[b] = seg;
    end
  endtask

  task automatic align_frame();
    int guard = 0;
    while (an == 8'h80 && guard < 100) begin @(negedge clk); guard++; end
    while (an != 8'h80 && guard < 200) begin @(negedge clk); guard++; end
    checks++;
    if (an !== 8'h80) begin
      failures++;
      $display("FAIL align_timeout an=%h want 80", an);
    end
  endtask

  task automatic pulse_page();
    @(negedge clk); page_pulse = 1'b1;
    @(negedge clk); page_pulse = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== 8'h00 || an !== 8'h00) begin
      failures++;
      $display("FAIL reset_hold seg=%h an=%h want 00 00", seg, an);
    end
    reset = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++;
      if (an !== 8'h00 || seg !== 8'h00) begin
        failures++;
        $display("FAIL idle_off c=%0d seg=%h an=%h want 00 00", c, seg, an);
      end
    end
  endtask

  task automatic test_clock_page();
    logic [7:0] want [7:0];
    want = '{8'h06, 8'h5B, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D};
    @(negedge clk);
    power_on = 1'b1; hour = 6'd12; minute = 6'd34; second = 6'd56;
    capture(80);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (seen[b] !== want[b]) begin
        failures++;
        $display("FAIL clock_page an_bit=%0d seg=%h want %h", b, seen[b], want[b]);
      end
    end
  endtask

  task automatic test_page_cycle();
    logic [7:0] w1 [7:0];
    logic [7:0] w2 [7:0];
    logic [7:0] w0 [7:0];
    w1 = '{8'h76, 8'h00, 8'h00, 8'h7D, 8'h4F, 8'h40, 8'h3F, 8'h6D};
    w2 = '{8'h38, 8'h06, 8'h3F, 8'h00, 8'h00, 8'h73, 8'h3F, 8'h07};
    w0 = '{8'h06, 8'h5B, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D};
    work_hours = 6'd63; work_minutes = 6'd5; smoke_lvl = 4'd10; hand_time = 6'd7;
    pulse_page();
    capture(80);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (seen[b] !== w1[b]) begin
        failures++;
        $display("FAIL page_work an_bit=%0d seg=%h want %h", b, seen[b], w1[b]);
      end
    end
    pulse_page();
    capture(80);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (seen[b] !== w2[b]) begin
        failures++;
        $display("FAIL page_level an_bit=%0d seg=%h want %h", b, seen[b], w2[b]);
      end
    end
    pulse_page();
    capture(80);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (seen[b] !== w0[b]) begin
        failures++;
        $display("FAIL page_wrap an_bit=%0d seg=%h want %h", b, seen[b], w0[b]);
      end
    end
  endtask

  task automatic test_snapshot();
    minute = 6'd9;
    capture(80);
    align_frame();
    repeat (8) @(negedge clk);
    minute = 6'd10;
    capture(20);
    checks++;
    if (seen[4] !== 8'h3F || seen[3] !== 8'h6F) begin
      failures++;
      $display("FAIL snapshot_old min=%h%h want 3f6f", seen[4], seen[3]);
    end
    capture(40);
    checks++;
    if (seen[4] !== 8'h06 || seen[3] !== 8'h3F) begin
      failures++;
      $display("FAIL snapshot_new min=%h%h want 063f", seen[4], seen[3]);
    end
    minute = 6'd34;
  endtask

  task automatic test_blink();
    int blanks = 0;
    remind = 1'b1;
    align_frame();
    for (int c = 0; c < 96; c++) begin
      if (c > 0) @(negedge clk);
      if (seg == 8'h00) blanks++;
      checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        failures++;
        $display("FAIL blink c=%0d seg=%h an=%h want %h %h", c, seg, an, exp_seg, exp_an);
      end
      checks++;
      if (!$onehot(an)) begin
        failures++;
        $display("FAIL blink_onehot c=%0d an=%h want one-hot", c, an);
      end
    end
    checks++;
    if (blanks !== 48) begin
      failures++;
      $display("FAIL blink_count blanks=%0d want 48", blanks);
    end
    remind = 1'b0;
  endtask

  task automatic test_power_race();
    int wait_cyc = 0;
    logic [7:0] w0 [7:0];
    w0 = '{8'h06, 8'h5B, 8'h40, 8'h4F, 8'h66, 8'h40, 8'h6D, 8'h7D};
    pulse_page();
    repeat (10) @(negedge clk);
    power_on = 1'b0; page_pulse = 1'b1;
    @(negedge clk);
    page_pulse = 1'b0;
    checks++;
    if (an !== 8'h00 || seg !== 8'h00) begin
      failures++;
      $display("FAIL power_race seg=%h an=%h want 00 00", seg, an);
    end
    repeat (5) @(negedge clk);
    power_on = 1'b1;
    while (an == 8'h00 && wait_cyc < 8) begin @(negedge clk); wait_cyc++; end
    checks++;
    if (wait_cyc > SCAN || !$onehot(an) || an !== exp_an) begin
      failures++;
      $display("FAIL power_up wait=%0d an=%h want <=%0d %h", wait_cyc, an, SCAN, exp_an);
    end
    capture(80);
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (seen[b] !== w0[b]) begin
        failures++;
        $display("FAIL power_page0 an_bit=%0d seg=%h want %h", b, seen[b], w0[b]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    repeat (13) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (seg !== 8'h00 || an !== 8'h00) begin
      failures++;
      $display("FAIL reset_async seg=%h an=%h want 00 00", seg, an);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 8'h00) begin
      failures++;
      $display("FAIL reset_release an=%h want 00", an);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        failures++;
        $display("FAIL post_reset c=%0d seg=%h an=%h want %h %h", c, seg, an, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      checks++;
      if (seg !== exp_seg || an !== exp_an) begin
        failures++;
        $display("FAIL random c=%0d seg=%h an=%h want %h %h", c, seg, an, exp_seg, exp_an);
      end
      checks++;
      if (!$onehot0(an)) begin
        failures++;
        $display("FAIL random_onehot c=%0d an=%h want one-hot or 00", c, an);
      end
      page_pulse = ($urandom_range(0, 9) == 0);
      if (c % 37 == 0) begin
        hour         = 6'($urandom_range(0, 59));
        minute       = 6'($urandom_range(0, 59));
        second       = 6'($urandom_range(0, 59));
        work_hours   = 6'($urandom_range(0, 63));
        work_minutes = 6'($urandom_range(0, 63));
        smoke_lvl    = 4'($urandom_range(0, 15));
        hand_time    = 6'($urandom_range(0, 63));
        remind       = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 149) == 0) power_on = ~power_on;
    end
    page_pulse = 1'b0;
    power_on = 1'b1;
  endtask

  initial begin
    test_reset();
    test_clock_page();
    test_page_cycle();
    test_snapshot();
    test_blink();
    test_power_race();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
